// File: rtl/icache_lite_if.sv
// Fetch-side and refill-side signal bundle for icache_lite.
// slave is the cache's view; master is the fetch unit / memory environment.
interface icache_lite_if;
  logic        req;
  logic [31:0] addr;
  logic        kill;
  logic        flush;
  logic        ack;
  logic [31:0] r_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;

  modport slave (
    input  req, addr, kill, flush, mem_ack, mem_rdata,
    output ack, r_data, mem_req, mem_addr, busy
  );

  modport master (
    output req, addr, kill, flush, mem_ack, mem_rdata,
    input  ack, r_data, mem_req, mem_addr, busy
  );
endinterface

// File: rtl/icache_lite.sv
// Direct-mapped instruction cache with combinational hit path and
// sequential line refill; flush invalidates every line.
module icache_lite #(
  parameter int unsigned NUM_LINES  = 16,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  icache_lite_if.slave  bus
);

  localparam int unsigned OFF_W  = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W  = $clog2(NUM_LINES);
  localparam int unsigned BASE_W = 32 - 2 - OFF_W;
  localparam int unsigned TAG_W  = BASE_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, REFILL, FLUSH} state_t;

  state_t                 state_q, state_d;
  logic [OFF_W-1:0]       beat_q, beat_d;
  logic                   pend_q, pend_d;
  logic [BASE_W-1:0]      base_q, base_d;
  logic [NUM_LINES-1:0]   valid_q, valid_d;

  logic [TAG_W-1:0]       tag_mem  [NUM_LINES];
  logic [31:0]            data_mem [NUM_LINES][LINE_WORDS];

  logic [OFF_W-1:0]       addr_off;
  logic [IDX_W-1:0]       addr_idx;
  logic [TAG_W-1:0]       addr_tag;
  logic [IDX_W-1:0]       base_idx;
  logic [TAG_W-1:0]       base_tag;
  logic                   hit_raw;
  logic                   fill_we;
  logic                   line_done;
  logic                   ack;
  logic [31:0]            r_data;
  logic                   mem_req;
  logic [31:0]            mem_addr;
  logic                   unused_addr_bits;

  assign addr_off = bus.addr[2 +: OFF_W];
  assign addr_idx = bus.addr[2 + OFF_W +: IDX_W];
  assign addr_tag = bus.addr[31 -: TAG_W];
  assign base_idx = base_q[IDX_W-1:0];
  assign base_tag = base_q[BASE_W-1 -: TAG_W];
  assign hit_raw  = valid_q[addr_idx] && (tag_mem[addr_idx] == addr_tag);
  assign unused_addr_bits = ^bus.addr[1:0];

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    pend_d    = pend_q;
    base_d    = base_q;
    valid_d   = valid_q;
    ack       = 1'b0;
    r_data    = NOP;
    mem_req   = 1'b0;
    mem_addr  = '0;
    fill_we   = 1'b0;
    line_done = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.flush) begin
          state_d = FLUSH;
        end else if (bus.req && !bus.kill) begin
          if (hit_raw) begin
            ack    = 1'b1;
            r_data = data_mem[addr_idx][addr_off];
          end else begin
            state_d           = REFILL;
            beat_d            = '0;
            base_d            = bus.addr[31:2+OFF_W];
            valid_d[addr_idx] = 1'b0;
          end
        end
      end

      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {base_q, beat_q, 2'b00};
        if (bus.flush) pend_d = 1'b1;
        if (bus.mem_ack) begin
          fill_we = 1'b1;
          beat_d  = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            line_done         = 1'b1;
            valid_d[base_idx] = 1'b1;
            // A flush arriving on the final beat still counts as pending.
            if (pend_q || bus.flush) begin
              state_d = FLUSH;
              pend_d  = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end

      FLUSH: begin
        valid_d = '0;
        pend_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      pend_q  <= 1'b0;
      base_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      pend_q  <= pend_d;
      base_q  <= base_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we)   data_mem[base_idx][beat_q] <= bus.mem_rdata;
    if (line_done) tag_mem[base_idx]          <= base_tag;
  end

  assign bus.ack      = ack;
  assign bus.r_data   = r_data;
  assign bus.mem_req  = mem_req;
  assign bus.mem_addr = mem_addr;
  assign bus.busy     = (state_q != IDLE);

endmodule
